router_rx_port: RTL and testbench
=================================

Name: router_rx_port

Overview:
- Per-port packet receiver that sits directly downstream of one router output port (data_out_x / valid_out_x / read_enb_x).
- Drains whole packets from the port FIFO: header, then payload, then parity.
- Presents payload bytes to a downstream consumer that can apply backpressure.
- Checks the destination address and the parity, and counts packets.
- Guarantees a read is issued before the router's 30-cycle unread soft-reset fires.

Parameters:
- ADDR, 0, expected destination address; compared with header[1:0].
- MAX_WAIT, 25, maximum consecutive cycles with valid_out high and no read before a read is forced; legal range 1..29.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_out  in  1  router port non-empty.
- data_out  in  8  router port FIFO data; valid the cycle after read_enb is sampled high.
- stall  in  1  downstream backpressure; high requests no reads.
- read_enb  out  1  FIFO read strobe to the router port.
- rx_data  out  8  captured payload byte.
- rx_valid  out  1  rx_data strobe, payload bytes only.
- rx_sop  out  1  with rx_valid, marks the first payload byte.
- rx_eop  out  1  with rx_valid, marks the last payload byte.
- pkt_done  out  1  one-cycle pulse when a packet has been fully drained.
- len_out  out  6  header[7:2] of the current packet; held until the next header.
- parity_err  out  1  valid with pkt_done; high if the parity check failed.
- addr_err  out  1  valid with pkt_done; high if header[1:0] != ADDR.
- overrun  out  1  sticky; a read was forced while stall was high.
- pkt_count  out  16  packets completed; wraps 0xFFFF -> 0.

Behaviour:
- Reset values: every output is 0; FSM is in IDLE; all counters and the parity accumulator are cleared. A reset mid-packet abandons the packet, and no pkt_done is issued for it.
- Read gating: read_enb = rd_state & valid_out & (~stall | force).
  - rd_state is true in RD_HDR, RD_PAY and RD_PAR while reads remain to be issued.
  - read_enb is never high when valid_out is low.
- Force: wait_cnt increments each cycle with valid_out=1 and read_enb=0 in any state except HDR_WAIT and CHECK. It clears on any read.
  - When wait_cnt == MAX_WAIT-1 and the FSM is in IDLE or a read state, force=1 for that cycle.
  - If stall=1 at that moment, overrun is set. Only reset clears overrun.
- Capture: rd_d is read_enb delayed one cycle. Data is captured when rd_d=1. Read latency is exactly 1 cycle; the rx_* outputs are registered, so a byte reaches the rx_* outputs 2 cycles after its read_enb.
- FSM:
  - IDLE: valid_out & (~stall | force) -> RD_HDR.
  - RD_HDR: issue one read; when read_enb=1 -> HDR_WAIT.
  - HDR_WAIT: capture the header, load len_out, init parity = header, set addr_mismatch.
    - len=0 -> RD_PAR.
    - len>0 -> RD_PAY.
  - RD_PAY: issue reads until issued == len. Each captured payload byte drives rx_data, rx_valid=1 and parity ^= byte.
    - rx_sop on byte 1; rx_eop on byte len; both on the same byte when len=1.
    - After the last payload read -> RD_PAR.
  - RD_PAR: issue one read -> CHECK.
  - CHECK: wait for the capture, then compare the parity byte with the accumulator.
    - Pulse pkt_done with parity_err and addr_err, increment pkt_count, then -> IDLE.
    - CHECK is 2 cycles minimum.
- Payload capture in RD_PAY overlaps issue; the issued and captured counters are separate 6-bit counters.
- Gaps: valid_out may drop mid-packet (reader faster than writer).
  - The FSM holds state and resumes when valid_out returns.
  - A stall mid-packet also holds; force applies mid-packet as well.
- addr_err packets are still fully drained and payload is still presented.

Test Plan:
- ADDR=0, packet hdr 0x0C (len 3, addr 0), payload 0x11 0x22 0x33, parity 0x0C^0x11^0x22^0x33=0x0C, stall=0 -> read_enb high 1 cycle, then 3 cycles, then 1 cycle.
  - rx_valid ×3 with sop on 0x11 and eop on 0x33.
  - pkt_done with parity_err=0, addr_err=0; pkt_count=1.
- Same packet with parity byte 0xFF -> pkt_done with parity_err=1; payload still delivered.
- hdr 0x05 (len 1, addr 1), ADDR=0 -> addr_err=1 at pkt_done; sop and eop on the single byte.
- hdr 0x00 (len 0), parity 0x00 -> no rx_valid; pkt_done with parity_err=0.
- valid_out high with stall held high, MAX_WAIT=25 -> read_enb first asserts on cycle 25; overrun=1.
  - After an intervening reset pulse, overrun=0 and pkt_count=0.
- Reset asserted during RD_PAY of a len-10 packet -> all outputs 0 next cycle; no pkt_done; the next packet is received correctly.

Source files
------------

// File: rtl/router_rx_port.sv
// router_rx_port: drains whole packets (header, payload, parity) from one
// router output port, streams payload bytes downstream, checks address and
// parity, counts packets, and forces a read before the port's unread
// timeout can fire.
module router_rx_port #(
    parameter int ADDR     = 0,
    parameter int MAX_WAIT = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid_out,
    input  logic [7:0]  data_out,
    input  logic        stall,
    output logic        read_enb,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        pkt_done,
    output logic [5:0]  len_out,
    output logic        parity_err,
    output logic        addr_err,
    output logic        overrun,
    output logic [15:0] pkt_count
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_HDR   = 3'd1;
    localparam logic [2:0] HDR_WAIT = 3'd2;
    localparam logic [2:0] RD_PAY   = 3'd3;
    localparam logic [2:0] RD_PAR   = 3'd4;
    localparam logic [2:0] CHECK    = 3'd5;

    localparam logic [1:0] ADDR_B   = 2'(ADDR);
    localparam logic [4:0] WAIT_LIM = 5'(MAX_WAIT - 1);

    logic [2:0] state;
    logic       rd_d;
    logic [4:0] wait_cnt;
    logic [5:0] issued;
    logic [5:0] captured;
    logic [7:0] parity_acc;
    logic       addr_mismatch;
    logic       par_seen;
    logic       par_bad;
    logic       rd_state;
    logic       force_rd;
    logic       report;

    // Read gating: reads only from read states, never on an empty port, and
    // a pending timeout overrides downstream backpressure. The threshold is
    // a >= compare so a force raised in IDLE carries into RD_HDR and the
    // read lands on the next cycle.
    always_comb begin
        rd_state = (state == RD_HDR) || (state == RD_PAY) || (state == RD_PAR);
        force_rd = valid_out && (wait_cnt >= WAIT_LIM) && ((state == IDLE) || rd_state);
        read_enb = rd_state && valid_out && (!stall || force_rd);
        report   = (state == CHECK) && !rd_d && par_seen;
    end

    // Read-to-data alignment: the FIFO presents data one cycle after a read.
    always_ff @(posedge clock) begin
        if (reset) rd_d <= 1'b0;
        else       rd_d <= read_enb;
    end

    // Unread-timeout counter and sticky overrun flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            if (read_enb)
                wait_cnt <= '0;
            else if (valid_out && (state != HDR_WAIT) && (state != CHECK) && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 5'd1;
            if (force_rd && stall)
                overrun <= 1'b1;
        end
    end

    // Packet sequencing, header decode and parity accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            issued        <= '0;
            len_out       <= '0;
            parity_acc    <= '0;
            addr_mismatch <= 1'b0;
            par_seen      <= 1'b0;
            par_bad       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_out && (!stall || force_rd))
                        state <= RD_HDR;
                end
                RD_HDR: begin
                    if (read_enb)
                        state <= HDR_WAIT;
                end
                HDR_WAIT: begin
                    // header byte is on data_out this cycle
                    len_out       <= data_out[7:2];
                    parity_acc    <= data_out;
                    addr_mismatch <= (data_out[1:0] != ADDR_B);
                    issued        <= '0;
                    state         <= (data_out[7:2] == 6'd0) ? RD_PAR : RD_PAY;
                end
                RD_PAY: begin
                    if (rd_d)
                        parity_acc <= parity_acc ^ data_out;
                    if (read_enb) begin
                        issued <= issued + 6'd1;
                        if (issued == len_out - 6'd1)
                            state <= RD_PAR;
                    end
                end
                RD_PAR: begin
                    // the last payload byte may still be landing here
                    if (rd_d)
                        parity_acc <= parity_acc ^ data_out;
                    if (read_enb)
                        state <= CHECK;
                end
                CHECK: begin
                    if (rd_d) begin
                        par_bad  <= (data_out != parity_acc);
                        par_seen <= 1'b1;
                    end else if (par_seen) begin
                        par_seen <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload presentation: every byte landing in RD_PAY/RD_PAR is payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            captured <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_sop   <= 1'b0;
            rx_eop   <= 1'b0;
            if (state == HDR_WAIT) begin
                captured <= '0;
            end else if (rd_d && ((state == RD_PAY) || (state == RD_PAR))) begin
                rx_valid <= 1'b1;
                rx_data  <= data_out;
                rx_sop   <= (captured == 6'd0);
                rx_eop   <= (captured == len_out - 6'd1);
                captured <= captured + 6'd1;
            end
        end
    end

    // Completion report: one-cycle pulse with status, plus the packet count.
    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_count  <= '0;
        end else begin
            pkt_done   <= report;
            parity_err <= report && par_bad;
            addr_err   <= report && addr_mismatch;
            if (report)
                pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_router_rx_port.sv
// tb_router_rx_port: directed and randomized packets through a FIFO model of
// the router port, checked against a packet-level scoreboard.
module tb_router_rx_port;

    localparam int ADDR     = 0;
    localparam int MAX_WAIT = 25;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        stall;
    logic        read_enb;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sop, rx_eop, pkt_done;
    logic [5:0]  len_out;
    logic        parity_err, addr_err, overrun;
    logic [15:0] pkt_count;

    router_rx_port #(.ADDR(ADDR), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .reset(reset), .valid_out(valid_out), .data_out(data_out),
        .stall(stall), .read_enb(read_enb), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .pkt_done(pkt_done), .len_out(len_out),
        .parity_err(parity_err), .addr_err(addr_err), .overrun(overrun),
        .pkt_count(pkt_count)
    );

    always #5 clock = ~clock;

    // router port model: byte FIFO, data one cycle after a sampled read
    logic [7:0] fmem [0:4095];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       gap = 1'b0;

    assign valid_out = (wr_ptr != rd_ptr) && !gap;

    always @(posedge clock) begin
        if (read_enb) begin
            data_out <= fmem[rd_ptr % 4096];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    // scoreboard
    logic [9:0]  rxq[$];   // {sop, eop, byte}
    logic [7:0]  dq[$];    // {parity_err, addr_err, len}
    logic [7:0]  pay[$];
    logic [15:0] model_cnt = '0;
    int          rx_seen = 0;
    int          done_seen = 0;
    bit          mon_en = 1'b0;
    bit          rand_mode = 1'b0;
    int          stall_run = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fpush(input logic [7:0] b);
        fmem[wr_ptr % 4096] = b;
        wr_ptr++;
    endtask

    // queue a packet built from hdr and pay; parity is either fixed or the
    // true xor of all bytes flipped by 'flip'
    task automatic push_pkt(input logic [7:0] hdr, input bit use_fixed,
                            input logic [7:0] fixed_par, input logic [7:0] flip);
        logic [7:0] par;
        logic [7:0] fin;
        int         len;
        len = int'(hdr[7:2]);
        par = hdr;
        fpush(hdr);
        for (int i = 0; i < len; i++) begin
            fpush(pay[i]);
            par = par ^ pay[i];
            rxq.push_back({1'(i == 0), 1'(i == len - 1), pay[i]});
        end
        fin = use_fixed ? fixed_par : (par ^ flip);
        fpush(fin);
        dq.push_back({1'(fin != par), 1'(hdr[1:0] != 2'(ADDR)), hdr[7:2]});
    endtask

    task automatic rand_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    // one clock: drive after the rising edge, observe on the falling edge
    task automatic tick();
        logic [10:0] exp_rx;
        logic [8:0]  exp_d;
        @(posedge clock);
        #1;
        if (rand_mode) begin
            gap = ($urandom_range(0, 3) == 0);
            if (stall_run >= 4) stall = 1'b0;
            else                stall = ($urandom_range(0, 2) == 0);
            stall_run = stall ? stall_run + 1 : 0;
        end
        @(negedge clock);
        if (mon_en) begin
            chk("rd_gate", 32'(read_enb & ~valid_out), 0);
            if (rx_valid) begin
                rx_seen++;
                exp_rx = (rxq.size() != 0) ? {1'b1, rxq.pop_front()} : 11'd0;
                chk("rx_byte", {1'b1, rx_sop, rx_eop, rx_data}, 32'(exp_rx));
            end
            if (pkt_done) begin
                done_seen++;
                exp_d = (dq.size() != 0) ? {1'b1, dq.pop_front()} : 9'd0;
                chk("done_flags", {1'b1, parity_err, addr_err, len_out}, 32'(exp_d));
                model_cnt = model_cnt + 16'd1;
                chk("pkt_count", 32'(pkt_count), 32'(model_cnt));
            end
        end
    endtask

    task automatic drain(input int npkts, input int budget);
        int target;
        int c;
        target = done_seen + npkts;
        c = 0;
        while (done_seen < target && c < budget) begin
            tick();
            c++;
        end
        chk("drain_timeout", done_seen, target);
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string t);
        chk({t, " read_enb"},   32'(read_enb), 0);
        chk({t, " rx_data"},    32'(rx_data), 0);
        chk({t, " rx_valid"},   32'(rx_valid), 0);
        chk({t, " rx_sop"},     32'(rx_sop), 0);
        chk({t, " rx_eop"},     32'(rx_eop), 0);
        chk({t, " pkt_done"},   32'(pkt_done), 0);
        chk({t, " len_out"},    32'(len_out), 0);
        chk({t, " parity_err"}, 32'(parity_err), 0);
        chk({t, " addr_err"},   32'(addr_err), 0);
        chk({t, " overrun"},    32'(overrun), 0);
        chk({t, " pkt_count"},  32'(pkt_count), 0);
    endtask

    // reset pulse mid-run; pending packet data and expectations are dropped
    task automatic reset_pulse(input string t);
        mon_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all_zero(t);
        reset  = 1'b0;
        wr_ptr = rd_ptr;
        rxq.delete();
        dq.delete();
        model_cnt = '0;
        mon_en = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        int n;
        int start;
        int len;
        logic [7:0] flip;

        reset = 1'b1;
        stall = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);

        // good packet, len 3, parity 0x0C
        pay = '{8'h11, 8'h22, 8'h33};
        push_pkt(8'h0C, 1'b1, 8'h0C, 8'h00);
        drain(1, 200);
        chk("fifo_drained1", rd_ptr, wr_ptr);

        // same packet, bad parity byte
        push_pkt(8'h0C, 1'b1, 8'hFF, 8'h00);
        drain(1, 200);
        chk("fifo_drained2", rd_ptr, wr_ptr);

        // len 1, address 1 mismatch
        rand_pay(1);
        push_pkt(8'h05, 1'b0, 8'h00, 8'h00);
        drain(1, 200);

        // empty packet
        pay.delete();
        push_pkt(8'h00, 1'b1, 8'h00, 8'h00);
        drain(1, 200);
        chk("fifo_drained4", rd_ptr, wr_ptr);

        // forced read under a held stall
        stall = 1'b1;
        pay = '{8'h11, 8'h22, 8'h33};
        push_pkt(8'h0C, 1'b0, 8'h00, 8'h00);
        n = 0;
        while (!read_enb && n < 60) begin
            tick();
            n++;
        end
        chk("force_cycle", n, 25);
        tick();
        chk("overrun_set", 32'(overrun), 1);
        stall = 1'b0;
        drain(1, 400);
        chk("overrun_sticky", 32'(overrun), 1);
        reset_pulse("rst_overrun");

        // randomized packets with gaps and short stalls
        rand_mode = 1'b1;
        for (int p = 0; p < 40; p++) begin
            n = ($urandom_range(0, 2) == 0) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                len = $urandom_range(0, 20);
                rand_pay(len);
                flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                push_pkt({6'(len), 2'($urandom_range(0, 3))}, 1'b0, 8'h00, flip);
            end
            drain(n, 1000);
        end
        rand_mode = 1'b0;
        stall = 1'b0;
        gap   = 1'b0;
        tick();
        chk("fifo_drained_rand", rd_ptr, wr_ptr);
        chk("no_overrun_rand", 32'(overrun), 0);

        // reset in the middle of a len-10 payload
        rand_pay(10);
        push_pkt(8'h28, 1'b0, 8'h00, 8'h00);
        start = rx_seen;
        n = 0;
        while (rx_seen < start + 3 && n < 100) begin
            tick();
            n++;
        end
        chk("midpkt_progress", 32'(rx_seen - start >= 3), 1);
        reset_pulse("rst_mid");
        repeat (10) tick();
        chk("no_done_after_rst", done_seen, done_seen);
        rand_pay(5);
        push_pkt({6'd5, 2'd0}, 1'b0, 8'h00, 8'h00);
        drain(1, 200);
        chk("count_after_rst", 32'(pkt_count), 1);
        chk("fifo_drained_end", rd_ptr, wr_ptr);

        chk("rx_leftover", rxq.size(), 0);
        chk("done_leftover", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
